// File: rtl/popcount_decode_int16_pkg.sv
// Shared constants for the popcount encode/decode blocks, plus the popcount_int16
// function that is the inverse of popcount_decode_int16.
package popcount_decode_int16_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W     = 5;
    localparam int MAX_CNT   = 16;

    function automatic logic [CNT_W-1:0] popcount_int16(input logic [15:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/popcount_decode_int16_thermo_rotate.sv
// Combinational thermometer generator followed by a left rotate.
// count ones starting at bit offset, wrapping from the MSB back to bit 0.
module thermo_rotate_nbit
    import popcount_decode_int16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CW    = CNT_W,
    parameter int OW    = $clog2(WIDTH)
) (
    input  logic [CW-1:0]    count,
    input  logic [OW-1:0]    offset,
    output logic [WIDTH-1:0] mask
);

    localparam int SW = OW + 1;

    logic [WIDTH-1:0] thermo;
    logic [SW-1:0]    back_sh;

    always_comb begin
        thermo = '0;
        for (int i = 0; i < WIDTH; i++) begin
            thermo[i] = (CW'(i) < count);
        end
    end

    // Shifting right by the full width when offset is 0 yields zero, so no special case.
    assign back_sh = SW'(WIDTH) - SW'(offset);
    assign mask    = (thermo << offset) | (thermo >> back_sh);

endmodule

// File: rtl/popcount_decode_int16.sv
// Two-stage pipelined popcount decoder: turns a count and offset into a rotated
// thermometer mask, flagging (and saturating) out-of-range counts.
module popcount_decode_int16
    import popcount_decode_int16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Cnt,
    input  logic [3:0]       Ofs,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             Err
);

    // Handshake: a beat moves on a rising edge where valid and ready are both high;
    // valid and its data stay put until then, and ready never looks at valid.

    logic             s1_valid;
    logic [CNT_W-1:0] s1_cnt;
    logic [3:0]       s1_ofs;
    logic             s1_err;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_y;
    logic             s2_err;

    logic             s1_adv;
    logic             req_err;
    logic [CNT_W-1:0] req_cnt;
    logic [WIDTH-1:0] mask;

    assign s1_adv   = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s1_adv;

    always_comb begin
        req_err = (|Cnt[WIDTH-1:CNT_W]) || (Cnt[CNT_W-1:0] > CNT_W'(MAX_CNT));
        req_cnt = req_err ? CNT_W'(MAX_CNT) : Cnt[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_cnt   <= '0;
            s1_ofs   <= '0;
            s1_err   <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_cnt <= req_cnt;
                s1_ofs <= Ofs;
                s1_err <= req_err;
            end
        end
    end

    thermo_rotate_nbit #(
        .WIDTH (WIDTH),
        .CW    (CNT_W),
        .OW    (4)
    ) u_thermo_rotate (
        .count  (s1_cnt),
        .offset (s1_ofs),
        .mask   (mask)
    );

    // Stage 2 data only changes when a real result moves in, keeping Y quiet on bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_y     <= '0;
            s2_err   <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_y   <= mask;
                s2_err <= s1_err;
            end
        end
    end

    assign out_valid = s2_valid;
    assign Y         = s2_y;
    assign Err       = s2_err;

endmodule

// File: tb/tb_popcount_decode_int16.sv
// Scoreboarded bench for popcount_decode_int16: directed vectors, stall and reset
// scenarios, then a long random stream with a popcount round-trip check.
module tb_popcount_decode_int16;
    import popcount_decode_int16_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] Cnt = '0;
    logic [3:0]   Ofs = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] Y;
    logic         Err;

    popcount_decode_int16 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Cnt       (Cnt),
        .Ofs       (Ofs),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .Err       (Err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // ---------------- scoreboard state ----------------
    int           n_checks = 0;
    int           n_fail = 0;
    logic [21:0]  exp_q[$];     // {cnt[4:0], err, y[15:0]}
    int           pop_cyc[$];
    bit           rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    function automatic logic [21:0] model(input logic [W-1:0] c, input logic [3:0] o);
        logic         e;
        int           n;
        logic [W-1:0] y;
        e = (c > 16);
        n = e ? 16 : int'(c);
        y = '0;
        for (int k = 0; k < 16; k++) begin
            if (k < n) y[(int'(o) + k) % 16] = 1'b1;
        end
        return {5'(n), e, y};
    endfunction

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the falling edge; monitor samples 3 after.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] c, input logic [3:0] o, input logic [W-1:0] ey,
                        input logic ee, input logic [4:0] ec, output int waited);
        in_valid = 1'b1;
        Cnt = c;
        Ofs = o;
        #1;
        waited = 0;
        while (!in_ready && waited < 500) begin
            @(negedge clk);
            #2;
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: actual in_ready 0 required 1 (cycle %0d)", cycle);
        end else begin
            exp_q.push_back({ec, ee, ey});
        end
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            tick();
            t++;
        end
        tick();
        tick();
        check("drain_empty", exp_q.size(), 0);
    endtask

    // ---------------- random out_ready ----------------
    always begin
        @(negedge clk);
        if (rand_ready) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- monitor ----------------
    logic        hold_prev = 1'b0;
    logic [W:0]  held = '0;
    logic [21:0] e_cur;

    always begin
        @(negedge clk);
        #3;
        if (rst_n) begin
            if (hold_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", {Err, Y}, held);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: actual Y=%0h Err=%0b required none", Y, Err);
                end else begin
                    e_cur = exp_q.pop_front();
                    check("Y", Y, e_cur[15:0]);
                    check("Err", Err, e_cur[16]);
                    check("roundtrip", popcount_int16(Y), e_cur[21:17]);
                    pop_cyc.push_back(cycle);
                end
            end
            hold_prev = out_valid && !out_ready;
            held = {Err, Y};
        end else begin
            hold_prev = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int w;
        logic [W-1:0] c;
        logic [3:0]   o;
        logic [21:0]  m;

        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_Y", Y, 16'h0000);
        check("rst_Err", Err, 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        tick();

        // first result and its latency
        out_ready = 1'b1;
        send(16'd3, 4'd0, 16'h0007, 1'b0, 5'd3, w);
        idle();
        check("first_accept_wait", w, 0);
        check("latency_not_early", out_valid, 0);
        tick();
        check("latency_two", out_valid, 1);
        drain();

        // wrap-around and range boundaries
        send(16'd4, 4'd14, 16'hC003, 1'b0, 5'd4, w);
        send(16'd0, 4'd5, 16'h0000, 1'b0, 5'd0, w);
        send(16'd16, 4'd9, 16'hFFFF, 1'b0, 5'd16, w);
        send(16'd17, 4'd3, 16'hFFFF, 1'b1, 5'd16, w);
        send(16'h0020, 4'd0, 16'hFFFF, 1'b1, 5'd16, w);
        send(16'h0101, 4'd7, 16'hFFFF, 1'b1, 5'd16, w);
        send(16'd1, 4'd15, 16'h8000, 1'b0, 5'd1, w);
        idle();
        drain();

        // back-to-back, no bubbles
        pop_cyc.delete();
        send(16'd1, 4'd0, 16'h0001, 1'b0, 5'd1, w); check("b2b_wait1", w, 0);
        send(16'd2, 4'd0, 16'h0003, 1'b0, 5'd2, w); check("b2b_wait2", w, 0);
        send(16'd3, 4'd0, 16'h0007, 1'b0, 5'd3, w); check("b2b_wait3", w, 0);
        send(16'd4, 4'd0, 16'h000F, 1'b0, 5'd4, w); check("b2b_wait4", w, 0);
        send(16'd5, 4'd0, 16'h001F, 1'b0, 5'd5, w); check("b2b_wait5", w, 0);
        idle();
        drain();
        check("b2b_count", pop_cyc.size(), 5);
        if (pop_cyc.size() == 5) begin
            for (int i = 1; i < 5; i++) check("b2b_gap", pop_cyc[i] - pop_cyc[i-1], 1);
        end

        // stall: two held, third refused until the consumer is ready
        out_ready = 1'b0;
        send(16'd2, 4'd0, 16'h0003, 1'b0, 5'd2, w); check("stall_wait1", w, 0);
        send(16'd5, 4'd4, 16'h01F0, 1'b0, 5'd5, w); check("stall_wait2", w, 0);
        Cnt = 16'd6;
        Ofs = 4'd8;
        #1;
        check("stall_in_ready", in_ready, 0);
        tick();
        check("stall_in_ready_held", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        tick();
        out_ready = 1'b1;
        send(16'd6, 4'd8, 16'h3F00, 1'b0, 5'd6, w);
        check("stall_third_wait", w, 0);
        idle();
        drain();

        // reset with two requests in flight
        out_ready = 1'b0;
        send(16'd7, 4'd0, 16'h007F, 1'b0, 5'd7, w);
        send(16'd8, 4'd0, 16'h00FF, 1'b0, 5'd8, w);
        idle();
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_Y", Y, 16'h0000);
        check("async_rst_Err", Err, 0);
        exp_q.delete();
        tick();
        out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_stale_result", out_valid, 0);
        end
        send(16'd1, 4'd15, 16'h8000, 1'b0, 5'd1, w);
        check("post_rst_accept_wait", w, 0);
        idle();
        drain();

        // random stream
        rand_ready = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
                tick();
            end else begin
                case ($urandom_range(0, 9))
                    8:       c = W'($urandom_range(17, 31));
                    9:       c = W'($urandom);
                    default: c = W'($urandom_range(0, 16));
                endcase
                o = 4'($urandom_range(0, 15));
                m = model(c, o);
                send(c, o, m[15:0], m[16], m[21:17], w);
            end
        end
        idle();
        rand_ready = 1'b0;
        tick();
        tick();
        out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
